// File: rtl/instr_encoder.sv
// RV32I/F instruction packer: range-checks and encodes instruction fields, then
// queues each legal word with its target byte address in a small FIFO.
module instr_encoder #(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = '0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_fmt,
  input  logic [6:0]  in_opcode,
  input  logic [2:0]  in_funct3,
  input  logic [6:0]  in_funct7,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_addr,
  output logic        err_sticky,
  output logic [7:0]  err_cnt
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  logic [31:0] word;
  logic        legal;
  logic        is_shift;

  logic [31:0] mem_instr [DEPTH];
  logic [31:0] mem_addr  [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   addr_ctr;
  logic [31:0]   last_instr, last_addr;
  logic          accept, push, pop, drop;

  assign is_shift = (in_opcode == 7'b0010011) &&
                    ((in_funct3 == 3'b001) || (in_funct3 == 3'b101));

  always_comb begin
    word  = '0;
    legal = 1'b0;
    case (fmt_e'(in_fmt))
      FMT_R: begin
        word  = {in_funct7, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        legal = 1'b1;
      end
      FMT_I: begin
        if (is_shift) begin
          word  = {in_funct7, in_imm[4:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = (in_imm[31:5] == '0);
        end else begin
          word  = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
          legal = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
        end
      end
      FMT_S: begin
        word  = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        legal = (in_imm[31:11] == '0) || (in_imm[31:11] == '1);
      end
      FMT_B: begin
        word  = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3,
                 in_imm[4:1], in_imm[11], in_opcode};
        legal = ((in_imm[31:12] == '0) || (in_imm[31:12] == '1)) && !in_imm[0];
      end
      FMT_U: begin
        word  = {in_imm[31:12], in_rd, in_opcode};
        legal = (in_imm[11:0] == '0);
      end
      FMT_J: begin
        word  = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        legal = ((in_imm[31:20] == '0) || (in_imm[31:20] == '1)) && !in_imm[0];
      end
      default: begin
        word  = '0;
        legal = 1'b0;
      end
    endcase
  end

  // clear outranks both handshakes; illegal requests still complete the handshake.
  assign in_ready  = (count != FULL_CNT);
  assign out_valid = (count != '0);
  assign accept    = in_valid && in_ready && !clear;
  assign push      = accept && legal;
  assign drop      = accept && !legal;
  assign pop       = out_valid && out_ready && !clear;

  // Once empty, the outputs keep showing the most recent head.
  assign out_instr = out_valid ? mem_instr[rd_ptr] : last_instr;
  assign out_addr  = out_valid ? mem_addr[rd_ptr]  : last_addr;

  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= word;
      mem_addr[wr_ptr]  <= addr_ctr;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      addr_ctr   <= BASE_ADDR;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
      last_instr <= '0;
      last_addr  <= '0;
    end else begin
      if (out_valid) begin
        last_instr <= mem_instr[rd_ptr];
        last_addr  <= mem_addr[rd_ptr];
      end
      if (clear) begin
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        count      <= '0;
        addr_ctr   <= BASE_ADDR;
        err_sticky <= 1'b0;
        err_cnt    <= '0;
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + 1'b1;
          addr_ctr <= addr_ctr + 32'd4;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: count <= count;
        endcase
        if (drop) begin
          err_sticky <= 1'b1;
          if (err_cnt != '1) err_cnt <= err_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: hand-encoded expected words are queued on
// accept and compared against the FIFO head every cycle.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n, clear, in_valid, out_ready;
  logic [2:0]  in_fmt, in_funct3;
  logic [6:0]  in_opcode, in_funct7;
  logic [4:0]  in_rd, in_rs1, in_rs2;
  logic [31:0] in_imm;
  logic        in_ready, out_valid, err_sticky;
  logic [31:0] out_instr, out_addr;
  logic [7:0]  err_cnt;
  logic        in_ready1, out_valid1, err_sticky1;
  logic [31:0] out_instr1, out_addr1;
  logic [7:0]  err_cnt1;

  int checks = 0;
  int errors = 0;

  typedef struct packed { logic [31:0] instr; logic [31:0] addr; } ent_t;
  ent_t        q[$];
  logic [31:0] m_addr = '0;
  int unsigned m_err = 0;
  logic        m_sticky = 1'b0;
  logic [31:0] last_instr_m = '0, last_addr_m = '0;
  logic        cur_legal = 1'b0;
  logic [31:0] cur_instr = '0;

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_addr(out_addr),
    .err_sticky(err_sticky), .err_cnt(err_cnt)
  );

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(32'hFFFF_FFFC)) dut_hi (
    .clk(clk), .rst_n(rst_n), .clear(clear), .in_valid(in_valid), .in_ready(in_ready1),
    .in_fmt(in_fmt), .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7(in_funct7),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .out_valid(out_valid1), .out_ready(out_ready), .out_instr(out_instr1), .out_addr(out_addr1),
    .err_sticky(err_sticky1), .err_cnt(err_cnt1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic req(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
                     input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [31:0] imm,
                     input logic legal, input logic [31:0] instr);
    logic took;
    in_fmt = fmt; in_opcode = op; in_funct3 = f3; in_funct7 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    cur_legal = legal; cur_instr = instr;
    in_valid = 1'b1;
    took = 1'b0;
    for (int n = 0; n < 50 && !took; n++) begin
      @(negedge clk);
      took = in_ready;
    end
    chk("accept_wait", took, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int n = 0; n < 20 && out_valid; n++) tick();
    chk("drain_empty", out_valid, 1'b0);
  endtask

  // Scoreboard: state checks, head compare, then model update for the coming edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_addr = '0; m_err = 0; m_sticky = 1'b0;
    end else begin
      chk("out_valid", out_valid, q.size() != 0);
      chk("in_ready", in_ready, q.size() < DEPTH);
      chk("err_cnt", err_cnt, m_err);
      chk("err_sticky", err_sticky, m_sticky);
      if (out_valid && q.size() != 0) begin
        chk("head_instr", out_instr, q[0].instr);
        chk("head_addr", out_addr, q[0].addr);
        if (out_ready && !clear) begin
          last_instr_m = q[0].instr;
          last_addr_m  = q[0].addr;
          void'(q.pop_front());
        end
      end
      if (clear) begin
        q.delete();
        m_addr = '0; m_err = 0; m_sticky = 1'b0;
      end else if (in_valid && in_ready) begin
        if (cur_legal) begin
          q.push_back('{instr: cur_instr, addr: m_addr});
          m_addr = m_addr + 32'd4;
        end else begin
          if (m_err != 255) m_err++;
          m_sticky = 1'b1;
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_fmt = '0; in_opcode = '0; in_funct3 = '0; in_funct7 = '0;
    in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_imm = '0;
    tick(); tick();
    rst_n = 1'b1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_instr", out_instr, 32'h0);
    chk("rst_out_addr", out_addr, 32'h0);
    chk("rst_err_cnt", err_cnt, 8'h0);
    chk("rst_in_ready", in_ready, 1'b1);

    out_ready = 1'b1;
    req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_instr", out_instr, 32'h0050_0093);
    chk("addi_addr", out_addr, 32'h0);
    req(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
    req(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd8, 1'b1, 32'h0080_00EF);
    req(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFFC, 1'b1, 32'hFE20_8EE3);
    req(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd3, 1'b0, 32'h0);
    tick();
    chk("beq_odd_sticky", err_sticky, 1'b1);
    chk("beq_odd_cnt", err_cnt, 8'd1);
    req(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 1'b1, 32'h1234_52B7);
    chk("lui_addr_no_skip", out_addr, 32'h10);

    // Legal boundaries and fields that must be ignored for the format.
    req(3'd2, 7'h23, 3'd2, 7'h7F, 5'h1F, 5'd1, 5'd2, 32'hFFFF_FFF8, 1'b1, 32'hFE20_AC23);
    req(3'd1, 7'h13, 3'd1, 7'h00, 5'd4, 5'd1, 5'd0, 32'd3, 1'b1, 32'h0030_9213);
    req(3'd1, 7'h13, 3'd5, 7'h20, 5'd4, 5'd1, 5'd0, 32'd31, 1'b1, 32'h41F0_D213);
    req(3'd1, 7'h13, 3'd0, 7'h7F, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800, 1'b1, 32'h8000_0093);
    req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2047, 1'b1, 32'h7FF0_0093);
    req(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd4094, 1'b1, 32'h7E00_0FE3);
    req(3'd5, 7'h6F, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'hFFF0_0000, 1'b1, 32'h8000_006F);
    // Just outside each legal range.
    req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd2048, 1'b0, 32'h0);
    req(3'd1, 7'h13, 3'd1, 7'h00, 5'd1, 5'd0, 5'd0, 32'd32, 1'b0, 32'h0);
    req(3'd4, 7'h37, 3'd0, 7'h00, 5'd5, 5'd0, 5'd0, 32'h1234_5123, 1'b0, 32'h0);
    req(3'd5, 7'h6F, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd3, 1'b0, 32'h0);
    req(3'd6, 7'h33, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
    req(3'd2, 7'h23, 3'd2, 7'h00, 5'd0, 5'd1, 5'd2, 32'hFFFF_F7FF, 1'b0, 32'h0);
    req(3'd3, 7'h63, 3'd0, 7'h00, 5'd0, 5'd1, 5'd2, 32'd4096, 1'b0, 32'h0);
    tick();
    chk("illegal_cnt", err_cnt, 8'd8);

    drain();
    out_ready = 1'b0;
    for (int i = 1; i <= 4; i++)
      req(3'd1, 7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, i, 1'b1, 32'h13 | (i << 20) | (i << 7));
    chk("full_in_ready", in_ready, 1'b0);
    chk("full_head", out_instr, 32'h0010_0093);
    out_ready = 1'b1;
    for (int i = 5; i <= 6; i++)
      req(3'd1, 7'h13, 3'd0, 7'h00, 5'(i), 5'd0, 5'd0, i, 1'b1, 32'h13 | (i << 20) | (i << 7));
    drain();
    chk("empty_hold_instr", out_instr, 32'h0060_0313);
    chk("empty_hold_addr", out_addr, last_addr_m);

    for (int i = 0; i < 300; i++)
      req(3'd7, 7'h00, 3'd0, 7'h00, 5'd0, 5'd0, 5'd0, 32'd0, 1'b0, 32'h0);
    tick();
    chk("sat_cnt", err_cnt, 8'd255);
    chk("sat_sticky", err_sticky, 1'b1);

    in_fmt = 3'd1; in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd5;
    cur_legal = 1'b1; cur_instr = 32'h0050_0093;
    in_valid = 1'b1; clear = 1'b1;
    tick();
    in_valid = 1'b0; clear = 1'b0;
    chk("clr_cnt", err_cnt, 8'd0);
    chk("clr_sticky", err_sticky, 1'b0);
    chk("clr_discard", out_valid, 1'b0);
    req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    chk("clr_base_addr", out_addr, 32'h0);
    drain();

    rst_n = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    out_ready = 1'b0;
    req(3'd1, 7'h13, 3'd0, 7'h00, 5'd1, 5'd0, 5'd0, 32'd5, 1'b1, 32'h0050_0093);
    req(3'd0, 7'h33, 3'd0, 7'h00, 5'd3, 5'd1, 5'd2, 32'd0, 1'b1, 32'h0020_81B3);
    chk("hi_addr0", out_addr1, 32'hFFFF_FFFC);
    chk("hi_instr0", out_instr1, 32'h0050_0093);
    chk("lo_addr0", out_addr, 32'h0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("hi_addr_wrap", out_addr1, 32'h0);
    chk("hi_instr1", out_instr1, 32'h0020_81B3);

    cur_legal = 1'b1; cur_instr = 32'h0050_0093;
    in_fmt = 3'd1; in_opcode = 7'h13; in_funct3 = 3'd0; in_rd = 5'd1; in_rs1 = 5'd0; in_imm = 32'd5;
    in_valid = 1'b1;
    tick();
    chk("burst_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_valid", out_valid, 1'b0);
    chk("midrst_valid_hi", out_valid1, 1'b0);
    chk("midrst_instr", out_instr, 32'h0);
    chk("midrst_addr_hi", out_addr1, 32'h0);
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    chk("hi_err_cnt", err_cnt1, 8'h0);
    chk("hi_err_sticky", err_sticky1, 1'b0);
    chk("hi_in_ready", in_ready1, 1'b1);
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
